// File: rtl/pc_stack_pkg.sv
// pc_stack_pkg: shared definitions for the program-counter / return-stack block.
//   PC_W_DEF, DEPTH_DEF : default parameter values for pc_stack.
//   pc_sel_t            : source chosen for the next program counter.
package pc_stack_pkg;

  localparam int PC_W_DEF  = 10;
  localparam int DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    SEL_INC = 2'd0,  // pc + 1
    SEL_TGT = 2'd1,  // jump / call destination
    SEL_POP = 2'd2   // return address from stack top
  } pc_sel_t;

endpackage

// File: rtl/lifo_mem.sv
// lifo_mem: DEPTH x PC_W register array backing the return-address stack.
//   clk   in  : write clock
//   we    in  : write enable, writes wdata to waddr on the rising edge
//   waddr in  : write index
//   wdata in  : write data
//   raddr in  : read index (asynchronous read)
//   rdata out : contents of entry raddr
// Contents are never reset.
module lifo_mem #(
  parameter int DEPTH = 16,
  parameter int PC_W  = 10,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [PC_W-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [PC_W-1:0] rdata
);

  logic [PC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pc_stack.sv
// pc_stack: registered program counter with a return-address LIFO.
//   clk      in  : clock, all state changes on the rising edge
//   reset    in  : synchronous active-high reset
//   s_inc    in  : 1 = sequential step, 0 = jump to target
//   push     in  : CALL - save pc+1, jump to target
//   pop      in  : RET - restore pc from stack top
//   target   in  : jump / call destination
//   err_clr  in  : clears the sticky error flags
//   pc       out : registered program counter
//   sp       out : stack occupancy 0..DEPTH
//   full     out : sp == DEPTH
//   empty    out : sp == 0
//   ovf      out : sticky, push while full
//   unf      out : sticky, pop while empty
//   conflict out : sticky, push and pop in the same cycle
// Build option: define PC_STACK_ERR_EN to compile in the sticky flags and
// err_clr; otherwise the flags read 0 and err_clr has no effect. PC and sp
// behaviour is identical in both builds.
module pc_stack
  import pc_stack_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH),
  localparam int SP_W = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_inc,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] target,
  input  logic            err_clr,
  output logic [PC_W-1:0] pc,
  output logic [SP_W-1:0] sp,
  output logic            full,
  output logic            empty,
  output logic            ovf,
  output logic            unf,
  output logic            conflict
);

  pc_sel_t         sel;
  logic            we;
  logic [SP_W-1:0] sp_nxt;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] top_data;
  logic            set_ovf;
  logic            set_unf;
  logic            set_conflict;

  assign full  = (sp == SP_W'(DEPTH));
  assign empty = (sp == '0);

  // Natural PC_W-bit wrap: the top address increments (and is stacked) as 0.
  assign pc_inc = pc + PC_W'(1);

  // Priority decode; push/pop outrank s_inc regardless of its value.
  always_comb begin
    sel          = SEL_INC;
    we           = 1'b0;
    sp_nxt       = sp;
    set_ovf      = 1'b0;
    set_unf      = 1'b0;
    set_conflict = 1'b0;
    if (push && pop) begin
      set_conflict = 1'b1;
    end else if (push) begin
      sel = SEL_TGT;
      if (!full) begin
        we     = 1'b1;
        sp_nxt = sp + SP_W'(1);
      end else begin
        set_ovf = 1'b1;
      end
    end else if (pop) begin
      if (!empty) begin
        sel    = SEL_POP;
        sp_nxt = sp - SP_W'(1);
      end else begin
        set_unf = 1'b1;
      end
    end else if (!s_inc) begin
      sel = SEL_TGT;
    end
  end

  always_comb begin
    pc_nxt = pc_inc;
    case (sel)
      SEL_TGT: pc_nxt = target;
      SEL_POP: pc_nxt = top_data;
      default: pc_nxt = pc_inc;
    endcase
  end

  // Reset suppresses the stack write so a push in the reset cycle is dropped.
  // Read index sp-1 wraps when empty; the value is unused in that case.
  lifo_mem #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) u_mem (
    .clk   (clk),
    .we    (we && !reset),
    .waddr (sp[AW-1:0]),
    .wdata (pc_inc),
    .raddr (sp[AW-1:0] - AW'(1)),
    .rdata (top_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
      sp <= '0;
    end else begin
      pc <= pc_nxt;
      sp <= sp_nxt;
    end
  end

`ifdef PC_STACK_ERR_EN
  // A new error in the same cycle as err_clr wins, so the flag ends set.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf      <= 1'b0;
      unf      <= 1'b0;
      conflict <= 1'b0;
    end else begin
      ovf      <= set_ovf      || (ovf      && !err_clr);
      unf      <= set_unf      || (unf      && !err_clr);
      conflict <= set_conflict || (conflict && !err_clr);
    end
  end
`else
  logic [3:0] unused_err;
  assign unused_err = {err_clr, set_ovf, set_unf, set_conflict};
  assign ovf      = 1'b0;
  assign unf      = 1'b0;
  assign conflict = 1'b0;
`endif

endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: directed, table-driven bench for pc_stack (PC_W=10, DEPTH=16).
// Expected sticky flags collapse to 0 unless PC_STACK_ERR_EN is defined.
module tb_pc_stack;

  localparam int PC_W  = 10;
  localparam int DEPTH = 16;
  localparam int SP_W  = $clog2(DEPTH) + 1;
`ifdef PC_STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            s_inc;
  logic            push;
  logic            pop;
  logic [PC_W-1:0] target;
  logic            err_clr;
  logic [PC_W-1:0] pc;
  logic [SP_W-1:0] sp;
  logic            full;
  logic            empty;
  logic            ovf;
  logic            unf;
  logic            conflict;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pc_stack #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_inc    (s_inc),
    .push     (push),
    .pop      (pop),
    .target   (target),
    .err_clr  (err_clr),
    .pc       (pc),
    .sp       (sp),
    .full     (full),
    .empty    (empty),
    .ovf      (ovf),
    .unf      (unf),
    .conflict (conflict)
  );

  typedef struct {
    logic            rst;
    logic            inc;
    logic            psh;
    logic            pp;
    logic [PC_W-1:0] tgt;
    logic            clr;
    int              e_pc;
    int              e_sp;
    logic            e_ovf;
    logic            e_unf;
    logic            e_cnf;
  } vec_t;

  vec_t vecs[$];

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic inc, input logic psh,
                       input logic pp, input logic [PC_W-1:0] tgt,
                       input logic clr);
    reset   = rst;
    s_inc   = inc;
    push    = psh;
    pop     = pp;
    target  = tgt;
    err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  // Compares every output against a model state.
  task automatic chk_all(input int idx, input int e_pc, input int e_sp,
                         input logic e_ovf, input logic e_unf, input logic e_cnf);
    chk("pc", idx, int'(pc), e_pc);
    chk("sp", idx, int'(sp), e_sp);
    chk("full", idx, int'(full), int'(e_sp == DEPTH));
    chk("empty", idx, int'(empty), int'(e_sp == 0));
    chk("ovf", idx, int'(ovf), int'(e_ovf & ERR_EN));
    chk("unf", idx, int'(unf), int'(e_unf & ERR_EN));
    chk("conflict", idx, int'(conflict), int'(e_cnf & ERR_EN));
  endtask

  function automatic vec_t mk(logic rst, logic inc, logic psh, logic pp,
                              int tgt, logic clr, int e_pc, int e_sp,
                              logic e_ovf, logic e_unf, logic e_cnf);
    vec_t v;
    v.rst = rst; v.inc = inc; v.psh = psh; v.pp = pp;
    v.tgt = PC_W'(tgt); v.clr = clr;
    v.e_pc = e_pc; v.e_sp = e_sp;
    v.e_ovf = e_ovf; v.e_unf = e_unf; v.e_cnf = e_cnf;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  logic [PC_W-1:0] exp_q[$];
  int              model_pc;

  initial begin
    reset = 1'b1; s_inc = 1'b0; push = 1'b0; pop = 1'b0;
    target = '0; err_clr = 1'b0;

    //               rst inc psh pop tgt  clr  pc   sp ovf unf cnf
    vecs.push_back(mk(1, 1,  0,  0,  0,   0,   0,   0, 0,  0,  0));
    vecs.push_back(mk(0, 1,  0,  0,  0,   0,   1,   0, 0,  0,  0));
    vecs.push_back(mk(0, 1,  0,  0,  0,   0,   2,   0, 0,  0,  0));
    vecs.push_back(mk(0, 1,  0,  0,  0,   0,   3,   0, 0,  0,  0));
    vecs.push_back(mk(0, 0,  0,  0,  5,   0,   5,   0, 0,  0,  0));
    vecs.push_back(mk(0, 1,  1,  0,  40,  0,   40,  1, 0,  0,  0));
    vecs.push_back(mk(0, 1,  0,  0,  0,   0,   41,  1, 0,  0,  0));
    vecs.push_back(mk(0, 1,  0,  0,  0,   0,   42,  1, 0,  0,  0));
    vecs.push_back(mk(0, 0,  0,  1,  77,  0,   6,   0, 0,  0,  0));
    vecs.push_back(mk(0, 0,  0,  0,  7,   0,   7,   0, 0,  0,  0));
    vecs.push_back(mk(0, 0,  0,  1,  99,  0,   8,   0, 0,  1,  0));
    vecs.push_back(mk(0, 1,  0,  0,  0,   1,   9,   0, 0,  0,  0));
    vecs.push_back(mk(0, 0,  0,  0,  12,  0,   12,  0, 0,  0,  0));
    vecs.push_back(mk(0, 0,  1,  1,  99,  0,   13,  0, 0,  0,  1));
    vecs.push_back(mk(0, 1,  1,  1,  99,  1,   14,  0, 0,  0,  1));
    vecs.push_back(mk(0, 1,  0,  0,  0,   1,   15,  0, 0,  0,  0));
    vecs.push_back(mk(0, 0,  0,  0,  1023,0,   1023,0, 0,  0,  0));
    vecs.push_back(mk(0, 1,  0,  0,  0,   0,   0,   0, 0,  0,  0));
    vecs.push_back(mk(0, 0,  0,  0,  1023,0,   1023,0, 0,  0,  0));
    vecs.push_back(mk(0, 1,  1,  0,  100, 0,   100, 1, 0,  0,  0));
    vecs.push_back(mk(0, 0,  1,  0,  200, 0,   200, 2, 0,  0,  0));
    vecs.push_back(mk(0, 1,  0,  1,  0,   0,   101, 1, 0,  0,  0));
    vecs.push_back(mk(0, 0,  0,  1,  0,   0,   0,   0, 0,  0,  0));
    vecs.push_back(mk(0, 0,  1,  0,  30,  0,   30,  1, 0,  0,  0));
    vecs.push_back(mk(1, 0,  1,  0,  300, 0,   0,   0, 0,  0,  0));
    vecs.push_back(mk(0, 1,  0,  1,  0,   0,   1,   0, 0,  1,  0));
    vecs.push_back(mk(1, 1,  0,  0,  0,   0,   0,   0, 0,  0,  0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].inc, vecs[i].psh, vecs[i].pp,
            vecs[i].tgt, vecs[i].clr);
      chk_all(i, vecs[i].e_pc, vecs[i].e_sp,
              vecs[i].e_ovf, vecs[i].e_unf, vecs[i].e_cnf);
    end

    // DEPTH pushes fill the stack; the extra push overflows.
    model_pc = 0;
    for (int k = 1; k <= DEPTH; k++) begin
      exp_q.push_back(PC_W'(model_pc + 1));
      model_pc = 10 * k + 3;
      drive(1'b0, 1'b1, 1'b1, 1'b0, PC_W'(model_pc), 1'b0);
      chk_all(100 + k, model_pc, k, 1'b0, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, PC_W'(500), 1'b0);
    chk_all(200, 500, DEPTH, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, PC_W'(0), 1'b1);
    chk_all(201, 501, DEPTH, 1'b0, 1'b0, 1'b0);

    // Unwind: each pop must return the most recent surviving push.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      model_pc = int'(exp_q.pop_back());
      drive(1'b0, 1'b0, 1'b0, 1'b1, PC_W'(900), 1'b0);
      chk_all(300 + k, model_pc, k, 1'b0, 1'b0, 1'b0);
    end

    // Pop after the stack drained sets underflow and steps the pc.
    drive(1'b0, 1'b1, 1'b0, 1'b1, PC_W'(0), 1'b0);
    chk_all(400, model_pc + 1, 0, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
# pc_stack

Program-counter and return-address stack for the 16-bit CPU. It consumes the `s_inc`, `push` and `pop` control lines produced by the control unit, together with the jump target field of the current instruction, and registers the next program counter. CALL pushes the return address into an internal LIFO. RET pops it back into the PC. The block sits between the control unit and the program memory address port.

## Interface
Parameters:
- `PC_W`, default 10: program counter width; addresses program memory.
- `DEPTH`, default 16: return-stack entries; must be a power of two, at least 2.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `s_inc`  in  1: 1 means sequential (PC+1); 0 means take `target`.
- `push`  in  1: CALL; save return address, jump to `target`.
- `pop`  in  1: RET; restore PC from stack top.
- `target`  in  PC_W: jump/call destination (instruction immediate field).
- `err_clr`  in  1: clears sticky error flags.
- `pc`  out  PC_W: registered program counter.
- `sp`  out  $clog2(DEPTH)+1: current stack occupancy, 0..DEPTH.
- `full`  out  1: `sp == DEPTH`.
- `empty`  out  1: `sp == 0`.
- `ovf`  out  1: sticky overflow flag.
- `unf`  out  1: sticky underflow flag.
- `conflict`  out  1: sticky flag, push and pop asserted together.

## Operation
Next-state priority per cycle, evaluated top to bottom; the first match wins:
1. `push && pop`: illegal. `pc <= pc+1`, stack unchanged, set `conflict`.
2. `push`, not full: `stack[sp] <= pc+1`, `sp <= sp+1`, `pc <= target`.
3. `push`, full: `pc <= target`, return address dropped, `sp` unchanged, set `ovf`.
4. `pop`, not empty: `pc <= stack[sp-1]`, `sp <= sp-1`.
5. `pop`, empty: `pc <= pc+1`, set `unf`.
6. `s_inc == 1`: `pc <= pc+1`.
7. `s_inc == 0`: `pc <= target`.

Arithmetic and flag rules:
- `push`/`pop` take precedence over `s_inc`, whatever `s_inc`'s value.
- PC arithmetic is modulo 2^PC_W. PC `2^PC_W-1` increments to 0.
- A return address pushed at the top address is stored as 0.
- Sticky flags hold until `err_clr` or `reset`.
- When `err_clr` and a new error occur in the same cycle, the flag ends set.
- `full`/`empty` are combinational from `sp`.

## Timing
- Latency: 1 cycle; controls sampled at edge N give the new `pc` after edge N.
- A pop at edge N+1 returns the value pushed at edge N; no bypass hazard, because the write completes at edge N.
- Reset values: `pc=0`, `sp=0`, `full=0`, `empty=1`, `ovf=0`, `unf=0`, `conflict=0`.
- Stack array contents are not reset; they are don't-care.
- Reset asserted in the same cycle as push/pop overrides them; no stack write occurs.
- Stack read is asynchronous from the array at index `sp-1`, feeding the `pc` register.

## Configuration
- `PC_STACK_ERR_EN` defined: `ovf`, `unf`, `conflict` registers and `err_clr` logic are compiled in, as described above.
- Without the macro: all three flags are tied to 0 and `err_clr` is ignored. Data-path behaviour for cases 1, 3 and 5 is unchanged (same PC and `sp` results).

## Structure
- Package `pc_stack_pkg` holds:
  - defaults `PC_W_DEF=10` and `DEPTH_DEF=16`;
  - a priority-case enum `pc_sel_t` with values `SEL_INC`, `SEL_TGT`, `SEL_POP`.
- One sub-module, `lifo_mem`: `DEPTH`×`PC_W` register array with synchronous write (`we`, `waddr`, `wdata`) and asynchronous read (`raddr`, `rdata`).
- Pointer, flags and PC mux stay in `pc_stack`.

## Test plan
- Reset, then `s_inc=1` held for 3 cycles -> `pc` steps 0,1,2,3; `empty=1`.
- At `pc=5`, `push` with `target=40` -> `pc=40`, `sp=1`. Two cycles of `s_inc` -> `pc=42`. `pop` -> `pc=6`, `sp=0`, `empty=1`.
- `DEPTH`+1 consecutive pushes -> `full=1` after the `DEPTH`-th push. The last push jumps to `target` with `sp` still `DEPTH` and `ovf=1`. `err_clr` pulse -> `ovf=0`.
- `pop` when empty at `pc=7` -> `pc=8`, `sp=0`, `unf=1`. With the macro undefined, `unf` stays 0 and `pc=8`.
- `push` and `pop` together at `pc=12` -> `pc=13`, `sp` unchanged, `conflict=1`.
- `pc=2^PC_W-1` with `s_inc=1` -> `pc=0`. Same PC with `push` -> stacked value 0, and a later pop returns `pc=0`.
